// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with input FIFO
module uart_tx_cfg #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_done,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 fifo_full,
    output logic                 overflow
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic              ODD_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    // Transmitter state
    state_t               state_q;
    state_t               state_d;
    logic [BAUD_W-1:0]    baud_q;
    logic [BAUD_W-1:0]    baud_d;
    logic [BIT_W-1:0]     bit_q;
    logic [BIT_W-1:0]     bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 tx_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;
    logic                 fd_q;
    logic                 fd_d;
    logic                 ovf_q;
    logic                 load;
    logic                 shift;
    logic                 begin_frame;
    logic                 baud_tc;

    // Full and empty come from the registered count, so a pop in the same
    // cycle never rescues a push into a full FIFO.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign push       = trmt && !fifo_full;
    assign baud_tc    = (baud_q == BAUD_LAST);

    assign TX         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign frame_done = fd_q;
    assign overflow   = ovf_q;

    // FIFO write side, pointers, occupancy and overflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= tx_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            ovf_q <= trmt && fifo_full;
        end
    end

    // Frame sequencer: next state, line level and status flags
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_tc ? '0 : baud_q + BAUD_W'(1);
        bit_d       = bit_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fd_d        = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        pop         = 1'b0;
        begin_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    begin_frame = 1'b1;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        shift = 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    if (bit_q == STOP_LAST) begin
                        fd_d = 1'b1;
                        if (!fifo_empty) begin
                            begin_frame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Starting a frame is shared by idle and the back-to-back stop exit
        if (begin_frame) begin
            state_d = S_START;
            pop     = 1'b1;
            load    = 1'b1;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            baud_d  = '0;
        end
    end

    // Sequencer registers, shift register and parity of the popped word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fd_q    <= fd_d;
            if (load) begin
                shift_q <= mem[rd_ptr];
                par_q   <= (^mem[rd_ptr]) ^ ODD_INV;
            end else if (shift) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt_w [4];
    logic [8:0] data_w [4];
    logic       tx_w   [4];
    logic       done_w [4];
    logic       fd_w   [4];
    logic       busy_w [4];
    logic       full_w [4];
    logic       ovf_w  [4];

    int checks = 0;
    int errors = 0;

    bit exp_tx[$];
    int fd_exp[$];
    int sched[$];
    bit cap_tx[$];
    bit cap_busy[$];
    bit cap_done[$];
    bit cap_fd[$];
    bit cap_ovf[$];
    bit cap_full[$];
    int fd_first;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_w[0]), .tx_data(data_w[0][7:0]),
        .TX(tx_w[0]), .tx_done(done_w[0]), .frame_done(fd_w[0]), .busy(busy_w[0]),
        .fifo_full(full_w[0]), .overflow(ovf_w[0]));

    uart_tx_cfg #(.CLK_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_w[1]), .tx_data(data_w[1][7:0]),
        .TX(tx_w[1]), .tx_done(done_w[1]), .frame_done(fd_w[1]), .busy(busy_w[1]),
        .fifo_full(full_w[1]), .overflow(ovf_w[1]));

    uart_tx_cfg #(.CLK_DIV(16), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_w[2]), .tx_data(data_w[2][6:0]),
        .TX(tx_w[2]), .tx_done(done_w[2]), .frame_done(fd_w[2]), .busy(busy_w[2]),
        .fifo_full(full_w[2]), .overflow(ovf_w[2]));

    uart_tx_cfg #(.CLK_DIV(2), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_w[3]), .tx_data(data_w[3][7:0]),
        .TX(tx_w[3]), .tx_done(done_w[3]), .frame_done(fd_w[3]), .busy(busy_w[3]),
        .fifo_full(full_w[3]), .overflow(ovf_w[3]));

    function automatic int cfg_div(input int i);
        return (i == 3) ? 2 : 16;
    endfunction
    function automatic int cfg_db(input int i);
        return (i == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_pen(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_podd(input int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_level(input bit v, input int n);
        for (int k = 0; k < n; k++) exp_tx.push_back(v);
    endtask

    // Reference line image of one frame: start, LSB-first data, parity, stops
    task automatic add_frame(input int inst, input int val);
        int n;
        bit p;
        n = cfg_div(inst);
        push_level(1'b0, n);
        p = bit'(cfg_podd(inst));
        for (int b = 0; b < cfg_db(inst); b++) begin
            push_level(bit'((val >> b) & 1), n);
            p = p ^ bit'((val >> b) & 1);
        end
        if (cfg_pen(inst) != 0) push_level(p, n);
        for (int s = 0; s < cfg_sb(inst); s++) push_level(1'b1, n);
        fd_exp.push_back(exp_tx.size());
    endtask

    // Push the first word; the captured window begins one edge later
    task automatic begin_test(input int inst, input int v0);
        exp_tx.delete();
        fd_exp.delete();
        sched.delete();
        exp_tx.push_back(1'b1);
        trmt_w[inst] = 1'b1;
        data_w[inst] = 9'(v0);
        tick();
        trmt_w[inst] = 1'b0;
    endtask

    task automatic run(input string tag, input int inst, input int ovf_idx);
        int len, mism, bgap, dearly, fdbad, nfd, novf, ovf_at;
        len = exp_tx.size();
        cap_tx.delete(); cap_busy.delete(); cap_done.delete();
        cap_fd.delete(); cap_ovf.delete(); cap_full.delete();
        for (int i = 0; i <= len; i++) begin
            cap_tx.push_back(tx_w[inst]);
            cap_busy.push_back(busy_w[inst]);
            cap_done.push_back(done_w[inst]);
            cap_fd.push_back(fd_w[inst]);
            cap_ovf.push_back(ovf_w[inst]);
            cap_full.push_back(full_w[inst]);
            if (i < sched.size()) begin
                trmt_w[inst] = 1'b1;
                data_w[inst] = 9'(sched[i]);
            end else begin
                trmt_w[inst] = 1'b0;
            end
            tick();
        end
        trmt_w[inst] = 1'b0;
        mism = 0; bgap = 0; dearly = 0; fdbad = 0; nfd = 0; novf = 0;
        ovf_at = -1; fd_first = -1;
        for (int i = 0; i < len; i++) if (cap_tx[i] != exp_tx[i]) mism++;
        for (int i = 1; i < len; i++) begin
            if (!cap_busy[i]) bgap++;
            if (cap_done[i]) dearly++;
        end
        for (int i = 0; i <= len; i++) begin
            if (cap_fd[i]) begin
                if (fd_first < 0) fd_first = i;
                if (nfd >= fd_exp.size() || fd_exp[nfd] != i) fdbad++;
                nfd++;
            end
            if (cap_ovf[i]) begin
                novf++;
                ovf_at = i;
            end
        end
        chk({tag, " idle before"}, int'(cap_busy[0]), 0);
        chk({tag, " line bit errors"}, mism, 0);
        chk({tag, " busy gaps"}, bgap, 0);
        chk({tag, " tx_done early"}, dearly, 0);
        chk({tag, " frame_done count"}, nfd, fd_exp.size());
        chk({tag, " frame_done misplaced"}, fdbad, 0);
        chk({tag, " tx_done at end"}, int'(cap_done[len]), 1);
        chk({tag, " busy at end"}, int'(cap_busy[len]), 0);
        chk({tag, " TX idle at end"}, int'(cap_tx[len]), 1);
        chk({tag, " overflow count"}, novf, (ovf_idx < 0) ? 0 : 1);
        if (ovf_idx >= 0) chk({tag, " overflow cycle"}, ovf_at, ovf_idx);
    endtask

    initial begin
        int v[6];
        int a5_bits[10];
        int bad, tlow, dhigh, fds;
        a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trmt_w[i] = 1'b0;
            data_w[i] = '0;
        end
        repeat (3) tick();
        chk("reset TX", int'(tx_w[0]), 1);
        chk("reset tx_done", int'(done_w[0]), 0);
        chk("reset busy", int'(busy_w[0]), 0);
        chk("reset fifo_full", int'(full_w[0]), 0);
        chk("reset overflow", int'(ovf_w[0]), 0);
        chk("reset frame_done", int'(fd_w[0]), 0);
        rst_n = 1'b1;
        tick();

        // 8N1 single frame, 0xA5
        begin_test(0, 'hA5);
        add_frame(0, 'hA5);
        run("8N1 A5", 0, -1);
        chk("8N1 latency idle", int'(cap_tx[0]), 1);
        chk("8N1 latency start", int'(cap_tx[1]), 0);
        chk("8N1 frame_done clock", fd_first - 1, 160);
        bad = 0;
        for (int k = 0; k < 10; k++) if (int'(cap_tx[1 + 16 * k + 8]) != a5_bits[k]) bad++;
        chk("8N1 A5 bit list", bad, 0);

        // 8E2, 0x03
        begin_test(1, 'h03);
        add_frame(1, 'h03);
        run("8E2 03", 1, -1);
        chk("8E2 parity bit", int'(cap_tx[1 + 16 * 9 + 8]), 0);
        chk("8E2 frame length", fd_first - 1, 192);

        // 7O1, 0x7F
        begin_test(2, 'h7F);
        add_frame(2, 'h7F);
        run("7O1 7F", 2, -1);
        chk("7O1 parity bit", int'(cap_tx[1 + 16 * 8 + 8]), 0);

        // Back-to-back three frames
        begin_test(0, 'h11);
        sched = '{'h22, 'h33};
        add_frame(0, 'h11);
        add_frame(0, 'h22);
        add_frame(0, 'h33);
        run("b2b", 0, -1);

        // Overflow: six consecutive pushes, the sixth is dropped
        for (int i = 0; i < 6; i++) v[i] = int'($urandom & 'hFF);
        begin_test(0, v[0]);
        for (int i = 1; i < 6; i++) sched.push_back(v[i]);
        for (int i = 0; i < 5; i++) add_frame(0, v[i]);
        run("overflow", 0, 5);
        chk("overflow fifo_full", int'(cap_full[4]), 1);
        chk("overflow not full before", int'(cap_full[3]), 0);

        // Random 8E2 burst
        for (int i = 0; i < 4; i++) v[i] = int'($urandom & 'hFF);
        begin_test(1, v[0]);
        for (int i = 1; i < 4; i++) sched.push_back(v[i]);
        for (int i = 0; i < 4; i++) add_frame(1, v[i]);
        run("8E2 random", 1, -1);

        // Minimum divisor, 0x00
        begin_test(3, 'h00);
        add_frame(3, 'h00);
        run("div2 00", 3, -1);
        chk("div2 frame length", fd_first - 1, 20);

        // Minimum divisor random burst
        for (int i = 0; i < 3; i++) v[i] = int'($urandom & 'hFF);
        begin_test(3, v[0]);
        for (int i = 1; i < 3; i++) sched.push_back(v[i]);
        for (int i = 0; i < 3; i++) add_frame(3, v[i]);
        run("div2 random", 3, -1);

        // 7O1 random pair
        for (int i = 0; i < 2; i++) v[i] = int'($urandom & 'h7F);
        begin_test(2, v[0]);
        sched.push_back(v[1]);
        for (int i = 0; i < 2; i++) add_frame(2, v[i]);
        run("7O1 random", 2, -1);

        // Reset during data bit 3
        trmt_w[0] = 1'b1;
        data_w[0] = 9'h0A5;
        tick();
        trmt_w[0] = 1'b0;
        tick();
        repeat (70) tick();
        chk("midframe data bit3", int'(tx_w[0]), 0);
        chk("midframe busy", int'(busy_w[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset TX", int'(tx_w[0]), 1);
        chk("async reset busy", int'(busy_w[0]), 0);
        chk("async reset tx_done", int'(done_w[0]), 0);
        chk("async reset frame_done", int'(fd_w[0]), 0);
        chk("async reset fifo_full", int'(full_w[0]), 0);
        chk("async reset overflow", int'(ovf_w[0]), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tlow = 0; dhigh = 0; fds = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!tx_w[0]) tlow++;
            if (done_w[0]) dhigh++;
            if (fd_w[0]) fds++;
        end
        chk("post reset TX low cycles", tlow, 0);
        chk("post reset tx_done cycles", dhigh, 0);
        chk("post reset frame_done", fds, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter for the serial link; successor to the fixed 8N1 transmitter.
- Configurable baud divisor, data width, parity and stop-bit count.
- Small input FIFO, so the host can queue several bytes and frames go out back-to-back with no idle gap.
- Sits between the command/telemetry logic and the TX pin.

Parameters:
- CLK_DIV, 5208: clocks per bit period; legal range 2..65535. The counter is $clog2(CLK_DIV) bits wide.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- FIFO_DEPTH, 4: queued words; must be a power of 2, range 2..16.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- trmt  input  1  one-cycle push request for tx_data
- tx_data  input  DATA_BITS  word to queue; sampled when trmt=1
- TX  output  1  serial line, registered, idles high
- tx_done  output  1  high when the transmitter is idle, the FIFO is empty and at least one frame has completed
- frame_done  output  1  one-cycle pulse at the end of each frame's last stop bit
- busy  output  1  high while a frame is on the line
- fifo_full  output  1  FIFO holds FIFO_DEPTH words
- overflow  output  1  one-cycle pulse when trmt arrives while fifo_full=1

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous active-low (rst_n). Every flop, including the counters, is reset.
- Reset values: TX=1, tx_done=0, frame_done=0, busy=0, fifo_full=0, overflow=0, FIFO empty, FSM in IDLE.
- Reset mid-frame: TX returns to 1 immediately, the queue is discarded and no frame_done is generated.
- FIFO push: trmt=1 with fifo_full=0 writes tx_data at the clock edge.
- FIFO full: trmt=1 with fifo_full=1 drops the word and pulses overflow. This holds even if a pop happens in the same cycle, because the full check uses the registered count.
- Push and pop in the same cycle with the FIFO not full: both take effect and the count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: when the FIFO is non-empty, pop the head into the shift register, TX<=0, busy<=1, tx_done<=0 and clear the baud counter.
- Latency: trmt in cycle 0 with the FIFO empty and the FSM idle makes TX fall at the 2nd rising edge after the trmt edge.
- Bit timing: every bit, including each stop bit, holds TX for exactly CLK_DIV clocks. The baud counter counts 0..CLK_DIV-1; the terminal count advances the bit and clears the counter.
- START -> DATA: DATA_BITS bits are sent LSB first, tracked by a bit counter.
- DATA -> PARITY when PARITY_EN=1, otherwise DATA -> STOP.
- Parity bit: XOR of the data bits for even parity; inverted XOR for odd parity.
- STOP: TX=1 for STOP_BITS*CLK_DIV clocks.
- Frame length: (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLK_DIV clocks, exactly.
- End of the last stop bit: frame_done pulses for 1 cycle.
  - FIFO non-empty: pop and go directly to START with TX<=0 in the same edge. There is no idle cycle, busy stays 1 and tx_done stays 0.
  - FIFO empty: go to IDLE, busy<=0, tx_done<=1.
- tx_done clears on the next pop. A push alone does not clear it.
- trmt during a frame never disturbs the frame in flight.
- Counter wrap: the bit counter and the FIFO pointers wrap modulo their widths. The FIFO count is FIFO_DEPTH values plus one, so it is $clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- Single frame, bench CLK_DIV=16, defaults: push 0xA5 -> TX = 0,1,0,1,0,0,1,0,1,1, each bit held 16 clocks. TX falls 2 edges after trmt. frame_done at clock 160 after the start. tx_done=1 afterwards.
- 8E2 and 7O1: with PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, push 0x03 -> parity bit 0, two stop bits, 192-clock frame. With DATA_BITS=7, PARITY_ODD=1, push 0x7F -> parity bit 0.
- Back-to-back: push 0x11, 0x22 and 0x33 on consecutive cycles:
  - three contiguous frames with no idle clocks;
  - busy high throughout;
  - three frame_done pulses;
  - tx_done high only after the third frame.
- Overflow, FIFO_DEPTH=4: 6 pushes on consecutive cycles while the FSM is idle. The first pops after entering; the remaining pushes fill to full; the last push -> one overflow pulse, and exactly 5 frames are transmitted.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> TX=1 asynchronously and all outputs at reset values. After release with no push, TX stays 1 and tx_done stays 0.
- Minimum divisor CLK_DIV=2: push 0x00 -> 20-clock frame, 2 clocks per bit, correct bit count, frame_done once.
